// File: rtl/ex_operand_bypass_unit.sv
// EX-stage operand bypass: tracks the last STAGES producers after EX, forwards the
// youngest matching result to ALU operands A/B and flags load-use hazards.
module ex_operand_bypass_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int STAGES         = 3,
    parameter int SELW           = $clog2(STAGES + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs,
    input  logic [REG_ADDR_WIDTH-1:0] i_rt,
    input  logic [DATA_WIDTH-1:0]     i_regA,
    input  logic [DATA_WIDTH-1:0]     i_regB,
    input  logic                      i_dest_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_dest_reg,
    input  logic                      i_is_load,
    input  logic [DATA_WIDTH-1:0]     i_aluresult,
    input  logic [DATA_WIDTH-1:0]     i_mem_data,
    input  logic                      i_flush,
    input  logic                      i_fwd_enable,
    output logic [DATA_WIDTH-1:0]     o_datoAAlu,
    output logic [DATA_WIDTH-1:0]     o_datoBAlu,
    output logic [SELW-1:0]           o_selA,
    output logic [SELW-1:0]           o_selB,
    output logic                      o_stall
);

    // Slot 0 is the instruction now in MEM; higher indices are older.
    logic                      slot_valid [STAGES];
    logic [REG_ADDR_WIDTH-1:0] slot_reg   [STAGES];
    logic                      slot_load  [STAGES];
    logic                      slot_ok    [STAGES];
    logic [DATA_WIDTH-1:0]     slot_data  [STAGES];

    logic stall_a;
    logic stall_b;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        o_datoAAlu = i_regA;
        o_datoBAlu = i_regB;
        o_selA     = '0;
        o_selB     = '0;
        stall_a    = 1'b0;
        stall_b    = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (i_fwd_enable && slot_valid[k] && (i_rs != '0) && (slot_reg[k] == i_rs)) begin
                o_datoAAlu = slot_data[k];
                o_selA     = SELW'(k + 1);
                stall_a    = !slot_ok[k];
            end
            if (i_fwd_enable && slot_valid[k] && (i_rt != '0) && (slot_reg[k] == i_rt)) begin
                o_datoBAlu = slot_data[k];
                o_selB     = SELW'(k + 1);
                stall_b    = !slot_ok[k];
            end
        end
    end

    assign o_stall = i_issue_valid & i_fwd_enable & (stall_a | stall_b);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                slot_valid[k] <= 1'b0;
                slot_reg[k]   <= '0;
                slot_load[k]  <= 1'b0;
                slot_ok[k]    <= 1'b0;
                slot_data[k]  <= '0;
            end
        end else if (i_flush) begin
            for (int k = 0; k < STAGES; k++) begin
                slot_valid[k] <= 1'b0;
            end
        end else begin
            for (int k = STAGES - 1; k >= 2; k--) begin
                slot_valid[k] <= slot_valid[k-1];
                slot_reg[k]   <= slot_reg[k-1];
                slot_load[k]  <= slot_load[k-1];
                slot_ok[k]    <= slot_ok[k-1];
                slot_data[k]  <= slot_data[k-1];
            end
            // Load data becomes available as the load leaves MEM.
            slot_valid[1] <= slot_valid[0];
            slot_reg[1]   <= slot_reg[0];
            slot_load[1]  <= slot_load[0];
            slot_ok[1]    <= 1'b1;
            slot_data[1]  <= slot_load[0] ? i_mem_data : slot_data[0];
            if (o_stall) begin
                // The stalled EX instruction is re-presented next cycle; insert a bubble.
                slot_valid[0] <= 1'b0;
                slot_reg[0]   <= '0;
                slot_load[0]  <= 1'b0;
                slot_ok[0]    <= 1'b0;
                slot_data[0]  <= '0;
            end else begin
                slot_valid[0] <= i_issue_valid & i_dest_valid & (i_dest_reg != '0);
                slot_reg[0]   <= i_dest_reg;
                slot_load[0]  <= i_is_load;
                slot_ok[0]    <= ~i_is_load;
                slot_data[0]  <= i_aluresult;
            end
        end
    end

endmodule

// File: tb/tb_ex_operand_bypass_unit.sv
// Bench for ex_operand_bypass_unit: directed scenarios plus random traffic, checked
// against a queue-based producer-history model.
module tb_ex_operand_bypass_unit;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int ST = 3;
    localparam int SW = $clog2(ST + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue;
    logic [AW-1:0] rs, rt, dest_reg;
    logic [DW-1:0] reg_a, reg_b, alu, mem_data;
    logic          dest_valid, is_load, flush, fwd_en;
    logic [DW-1:0] dato_a, dato_b;
    logic [SW-1:0] sel_a, sel_b;
    logic          stall;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic          valid;
        logic [AW-1:0] rg;
        logic          load;
        logic          known;
        logic [DW-1:0] val;
    } ent_t;
    ent_t hist[$];

    ex_operand_bypass_unit #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .STAGES(ST)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_issue_valid(issue), .i_rs(rs), .i_rt(rt),
        .i_regA(reg_a), .i_regB(reg_b), .i_dest_valid(dest_valid), .i_dest_reg(dest_reg),
        .i_is_load(is_load), .i_aluresult(alu), .i_mem_data(mem_data), .i_flush(flush),
        .i_fwd_enable(fwd_en), .o_datoAAlu(dato_a), .o_datoBAlu(dato_b), .o_selA(sel_a),
        .o_selB(sel_b), .o_stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_hist();
        ent_t e;
        e.valid = 1'b0; e.rg = '0; e.load = 1'b0; e.known = 1'b0; e.val = '0;
        hist.delete();
        repeat (ST) hist.push_back(e);
    endtask

    // Youngest valid producer of src, if forwarding applies.
    task automatic lookup(input logic [AW-1:0] src, output int idx, output logic known,
                          output logic [DW-1:0] val);
        idx = -1; known = 1'b1; val = '0;
        if (src != '0 && fwd_en) begin
            for (int i = 0; i < hist.size(); i++) begin
                if (hist[i].valid && hist[i].rg == src) begin
                    idx = i; known = hist[i].known; val = hist[i].val;
                    break;
                end
            end
        end
    endtask

    task automatic drive(input logic iv, input logic [AW-1:0] s, input logic [AW-1:0] t,
                         input logic dv, input logic [AW-1:0] d, input logic ld,
                         input logic [DW-1:0] res);
        issue = iv; rs = s; rt = t; dest_valid = dv; dest_reg = d; is_load = ld; alu = res;
        reg_a = $urandom; reg_b = $urandom; mem_data = $urandom;
        flush = 1'b0; fwd_en = 1'b1;
    endtask

    // Check current outputs against the model, then clock and advance the model.
    task automatic step(input string tag);
        int ia, ib;
        logic ka, kb, es;
        logic [DW-1:0] va, vb;
        ent_t e;
        lookup(rs, ia, ka, va);
        lookup(rt, ib, kb, vb);
        es = issue && ((ia >= 0 && !ka) || (ib >= 0 && !kb));
        check({tag, ".selA"}, DW'(sel_a), DW'(ia + 1));
        check({tag, ".selB"}, DW'(sel_b), DW'(ib + 1));
        check({tag, ".stall"}, DW'(stall), DW'(es));
        if (ia < 0 || ka) check({tag, ".A"}, dato_a, (ia < 0) ? reg_a : va);
        if (ib < 0 || kb) check({tag, ".B"}, dato_b, (ib < 0) ? reg_b : vb);
        @(posedge clk);
        if (flush) begin
            clear_hist();
        end else begin
            e = hist[0];
            if (e.load) begin e.val = mem_data; e.known = 1'b1; hist[0] = e; end
            e.valid = !es && issue && dest_valid && (dest_reg != '0);
            e.rg = dest_reg; e.load = is_load && !es; e.known = !is_load; e.val = alu;
            hist.push_front(e);
            while (hist.size() > ST) void'(hist.pop_back());
        end
        #1;
    endtask

    task automatic run(input string tag);
        #2;
        step(tag);
    endtask

    initial begin
        clear_hist();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        reg_a = 5;
        #3;
        check("t1.rst.A", dato_a, 5);
        check("t1.rst.selA", DW'(sel_a), 0);
        check("t1.rst.stall", DW'(stall), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        reg_a = 5;
        #2;
        check("t1.rel.A", dato_a, 5);
        check("t1.rel.selA", DW'(sel_a), 0);
        step("t1");

        drive(1, 0, 0, 1, 3, 0, 32'h10); run("t2.add");
        drive(1, 3, 0, 0, 0, 0, 0); #2;
        check("t2.fwd1.A", dato_a, 32'h10);
        check("t2.fwd1.selA", DW'(sel_a), 1);
        step("t2.fwd1");
        drive(1, 3, 0, 0, 0, 0, 0); #2;
        check("t2.fwd2.A", dato_a, 32'h10);
        check("t2.fwd2.selA", DW'(sel_a), 2);
        step("t2.fwd2");

        drive(1, 0, 0, 1, 4, 1, 32'h100); run("t3.lw");
        drive(1, 4, 0, 0, 0, 0, 0); mem_data = 32'hAB; #2;
        check("t3.stall", DW'(stall), 1);
        check("t3.stall.selA", DW'(sel_a), 1);
        step("t3.stall");
        drive(1, 4, 0, 0, 0, 0, 0); #2;
        check("t3.re.A", dato_a, 32'hAB);
        check("t3.re.selA", DW'(sel_a), 2);
        check("t3.re.stall", DW'(stall), 0);
        step("t3.re");

        drive(1, 0, 0, 1, 7, 0, 32'h2); run("t4.w2");
        drive(1, 0, 0, 1, 7, 0, 32'h1); run("t4.w1");
        drive(1, 0, 7, 1, 0, 0, 32'h55); #2;
        check("t4.young.B", dato_b, 32'h1);
        check("t4.young.selB", DW'(sel_b), 1);
        step("t4.young");
        drive(1, 0, 0, 0, 0, 0, 0); #2;
        check("t4.r0.A", dato_a, reg_a);
        check("t4.r0.selA", DW'(sel_a), 0);
        step("t4.r0");

        drive(1, 0, 0, 1, 5, 0, 32'h5A); run("t5.w5");
        drive(1, 0, 0, 0, 0, 0, 0); flush = 1'b1; run("t5.flush");
        drive(1, 5, 0, 0, 0, 0, 0); #2;
        check("t5.post.A", dato_a, reg_a);
        check("t5.post.selA", DW'(sel_a), 0);
        step("t5.post");
        drive(1, 0, 0, 1, 6, 1, 0); run("t5.lw");
        drive(1, 6, 0, 0, 0, 0, 0); flush = 1'b1; #2;
        check("t5.fs.stall", DW'(stall), 1);
        step("t5.fs");
        drive(1, 6, 6, 0, 0, 0, 0); #2;
        check("t5.fs2.selA", DW'(sel_a), 0);
        check("t5.fs2.selB", DW'(sel_b), 0);
        check("t5.fs2.stall", DW'(stall), 0);
        step("t5.fs2");

        drive(1, 0, 0, 1, 3, 0, 32'h33); run("t6.w3");
        drive(1, 3, 0, 0, 0, 0, 0); fwd_en = 1'b0; #2;
        check("t6.off.selA", DW'(sel_a), 0);
        check("t6.off.A", dato_a, reg_a);
        step("t6.off");
        drive(1, 3, 0, 0, 0, 0, 0); #2;
        check("t6.on.A", dato_a, 32'h33);
        check("t6.on.selA", DW'(sel_a), 2);
        step("t6.on");
        drive(1, 0, 0, 1, 9, 1, 0); run("t6.lw");
        drive(1, 9, 9, 0, 0, 0, 0); fwd_en = 1'b0; #2;
        check("t6.lwoff.stall", DW'(stall), 0);
        step("t6.lwoff");

        drive(1, 0, 0, 1, 2, 0, 32'h22); run("t7.w2");
        drive(1, 2, 0, 0, 0, 0, 0); #2;
        rst_n = 1'b0; #1;
        check("t7.arst.selA", DW'(sel_a), 0);
        check("t7.arst.A", dato_a, reg_a);
        clear_hist();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;

        repeat (400) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0), $urandom);
            flush  = ($urandom_range(0, 19) == 0);
            fwd_en = ($urandom_range(0, 9) != 0);
            run("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
